// File: rtl/capture_uart_sequencer.sv
// capture_uart_sequencer: arms the debug capture RAM write side, waits for the
// buffer to settle, then dumps the RAM contents over the UART transmit port
// behind a 4-byte header (A5 5A frame_hi frame_lo).
//
// UART handshake: a byte is offered by raising uart_txd_strobe for exactly one
// cycle, only when uart_txd_ready was high and the strobe was low in the cycle
// before; uart_txd carries the byte from the strobe cycle until the next strobe.
module capture_uart_sequencer #(
    parameter int ADDR_WIDTH    = 13,
    parameter int DATA_WIDTH    = 8,
    parameter int SETTLE_CYCLES = 4194303,
    parameter int AUTO_REARM    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    output logic                  capture_start,
    output logic                  capture_enable,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [7:0]            uart_txd,
    output logic                  uart_txd_strobe,
    input  logic                  uart_txd_ready,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int BW = $clog2(NB + 1);

    // LOAD is the cycle after FETCH, when rd_data for the new rd_addr is valid.
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_FILL, S_HDR, S_FETCH, S_LOAD, S_SEND, S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   settle_cnt;
    logic [1:0]      hdr_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]   byte_idx;
    logic            can_send;
    logic [7:0]      hdr_byte;

    // State register; reset aborts any dump in progress.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (AUTO_REARM != 0 || trigger) state_next = S_ARM;
            S_ARM:   state_next = S_FILL;
            S_FILL:  if (settle_cnt <= CW'(1)) state_next = S_HDR;
            S_HDR:   if (can_send && hdr_idx == 2'd3) state_next = S_FETCH;
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_SEND;
            S_SEND: begin
                if (can_send && byte_idx == BW'(1))
                    state_next = (&rd_addr) ? S_DONE : S_FETCH;
            end
            S_DONE:  state_next = (AUTO_REARM != 0) ? S_ARM : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Combinational outputs: busy flag, send permission and header byte mux.
    always_comb begin
        busy     = (state != S_IDLE);
        can_send = uart_txd_ready && !uart_txd_strobe;
        hdr_byte = 8'hA5;
        case (hdr_idx)
            2'd0: hdr_byte = 8'hA5;
            2'd1: hdr_byte = 8'h5A;
            2'd2: hdr_byte = frame_count[15:8];
            2'd3: hdr_byte = frame_count[7:0];
            default: hdr_byte = 8'hA5;
        endcase
    end

    // Datapath registers: capture control, settle counter, byte streaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture_start   <= 1'b0;
            capture_enable  <= 1'b0;
            rd_addr         <= '0;
            uart_txd        <= 8'h00;
            uart_txd_strobe <= 1'b0;
            frame_count     <= 16'h0000;
            settle_cnt      <= '0;
            hdr_idx         <= 2'd0;
            shift_reg       <= '0;
            byte_idx        <= '0;
        end else begin
            uart_txd_strobe <= 1'b0;
            case (state)
                S_ARM: begin
                    capture_start  <= ~capture_start;
                    capture_enable <= 1'b1;
                    settle_cnt     <= CW'(SETTLE_CYCLES);
                    rd_addr        <= '0;
                    hdr_idx        <= 2'd0;
                end
                S_FILL: settle_cnt <= settle_cnt - CW'(1);
                S_HDR: begin
                    if (can_send) begin
                        uart_txd_strobe <= 1'b1;
                        uart_txd        <= hdr_byte;
                        hdr_idx         <= hdr_idx + 2'd1;
                        // Freeze the buffer as the first header byte goes out.
                        if (hdr_idx == 2'd0) capture_enable <= 1'b0;
                    end
                end
                S_LOAD: begin
                    shift_reg <= rd_data;
                    byte_idx  <= BW'(NB);
                end
                S_SEND: begin
                    if (can_send) begin
                        uart_txd_strobe <= 1'b1;
                        uart_txd        <= shift_reg[DATA_WIDTH-1 -: 8];
                        shift_reg       <= shift_reg << 8;
                        byte_idx        <= byte_idx - BW'(1);
                        if (byte_idx == BW'(1))
                            rd_addr <= (&rd_addr) ? '0 : rd_addr + ADDR_WIDTH'(1);
                    end
                end
                S_DONE: frame_count <= frame_count + 16'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_uart_sequencer.sv
// Directed bench for capture_uart_sequencer: one instance with manual trigger
// (dut_a) and one auto-rearming instance (dut_b), each with a registered RAM
// model (RAM[i] = 16'h1000 + i) and a transmitter that drops ready for 3 clk
// after every strobe.
module tb_capture_uart_sequencer;

    localparam int AW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A (AUTO_REARM = 0) ----------------
    logic          reset_a = 1'b1;
    logic          trigger_a = 1'b0;
    logic          cap_start_a, cap_en_a, strb_a, rdy_a, busy_a;
    logic [AW-1:0] rd_addr_a;
    logic [DW-1:0] rd_data_a = '0;
    logic [7:0]    txd_a;
    logic [15:0]   fc_a;
    logic          hold_a = 1'b0;
    logic [1:0]    rdy_cnt_a = 2'd0;

    capture_uart_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_CYCLES(4), .AUTO_REARM(0)
    ) dut_a (
        .clk(clk), .reset(reset_a), .trigger(trigger_a),
        .capture_start(cap_start_a), .capture_enable(cap_en_a),
        .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .uart_txd(txd_a), .uart_txd_strobe(strb_a), .uart_txd_ready(rdy_a),
        .busy(busy_a), .frame_count(fc_a)
    );

    always @(posedge clk) rd_data_a <= 16'h1000 + 16'(rd_addr_a);
    always @(posedge clk) begin
        if (strb_a) rdy_cnt_a <= 2'd3;
        else if (rdy_cnt_a != 2'd0) rdy_cnt_a <= rdy_cnt_a - 2'd1;
    end
    assign rdy_a = (rdy_cnt_a == 2'd0) && !hold_a;

    // ---------------- instance B (AUTO_REARM = 1) ----------------
    logic          reset_b = 1'b1;
    logic          cap_start_b, cap_en_b, strb_b, rdy_b, busy_b;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_b = '0;
    logic [7:0]    txd_b;
    logic [15:0]   fc_b;
    logic [1:0]    rdy_cnt_b = 2'd0;

    capture_uart_sequencer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_CYCLES(4), .AUTO_REARM(1)
    ) dut_b (
        .clk(clk), .reset(reset_b), .trigger(1'b0),
        .capture_start(cap_start_b), .capture_enable(cap_en_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .uart_txd(txd_b), .uart_txd_strobe(strb_b), .uart_txd_ready(rdy_b),
        .busy(busy_b), .frame_count(fc_b)
    );

    always @(posedge clk) rd_data_b <= 16'h1000 + 16'(rd_addr_b);
    always @(posedge clk) begin
        if (strb_b) rdy_cnt_b <= 2'd3;
        else if (rdy_cnt_b != 2'd0) rdy_cnt_b <= rdy_cnt_b - 2'd1;
    end
    assign rdy_b = (rdy_cnt_b == 2'd0);

    // ---------------- monitors and scoreboard ----------------
    logic [7:0] rx_a[$];
    logic [7:0] rx_b[$];
    logic [7:0] exp_q[$];
    int   en_cnt_a = 0;
    int   b2b_cnt  = 0;
    logic prev_strb_a = 1'b0;
    logic prev_strb_b = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(negedge clk) begin
        if (strb_a) rx_a.push_back(txd_a);
        if (strb_b) rx_b.push_back(txd_b);
        if (cap_en_a) en_cnt_a++;
        if ((strb_a && prev_strb_a) || (strb_b && prev_strb_b)) b2b_cnt++;
        prev_strb_a = strb_a;
        prev_strb_b = strb_b;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected 20-byte dump: header then words 0x1000..0x1007, MSB byte first.
    task automatic build_exp(input logic [15:0] fc);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(fc[15:8]);
        exp_q.push_back(fc[7:0]);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'h10);
            exp_q.push_back(8'(i));
        end
    endtask

    task automatic cmp_dump_a(input string tag);
        check({tag, "_len"}, rx_a.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_a.size()) check($sformatf("%s_b%0d", tag, i), rx_a[i], exp_q[i]);
    endtask

    task automatic pulse_trigger_a();
        trigger_a = 1'b1;
        tick();
        trigger_a = 1'b0;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while (busy_a && n < 3000) begin
            tick();
            n++;
        end
        check(tag, busy_a, 1'b0);
    endtask

    task automatic wait_rx_a(input int want, input string tag);
        int n = 0;
        while (rx_a.size() < want && n < 3000) begin
            tick();
            n++;
        end
        check(tag, rx_a.size(), want);
    endtask

    task automatic wait_rx_b(input int want, input string tag);
        int n = 0;
        while (rx_b.size() < want && n < 6000) begin
            tick();
            n++;
        end
        check(tag, rx_b.size(), want);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        // Reset values.
        check("rst_start",  cap_start_a, 1'b0);
        check("rst_enable", cap_en_a,    1'b0);
        check("rst_addr",   rd_addr_a,   0);
        check("rst_txd",    txd_a,       8'h00);
        check("rst_strobe", strb_a,      1'b0);
        check("rst_busy",   busy_a,      1'b0);
        check("rst_fc",     fc_a,        16'h0000);
        reset_a = 1'b0;
        repeat (5) tick();
        check("idle_no_trig", busy_a, 1'b0);

        // 1: first dump.
        rx_a.delete();
        en_cnt_a = 0;
        pulse_trigger_a();
        wait_idle_a("t1_done");
        check("t1_start", cap_start_a, 1'b1);
        check("t1_en_cycles", en_cnt_a, 5);
        check("t1_en_low", cap_en_a, 1'b0);
        build_exp(16'h0000);
        cmp_dump_a("t1");
        check("t1_fc", fc_a, 16'h0001);

        // 2: second dump, header carries frame 1.
        rx_a.delete();
        pulse_trigger_a();
        wait_idle_a("t2_done");
        check("t2_start", cap_start_a, 1'b0);
        build_exp(16'h0001);
        cmp_dump_a("t2");
        check("t2_fc", fc_a, 16'h0002);

        // 3: transmitter stalls mid-word for 50 clk.
        rx_a.delete();
        pulse_trigger_a();
        wait_rx_a(5, "t3_reach5");
        hold_a = 1'b1;
        repeat (50) tick();
        check("t3_stall_cnt", rx_a.size(), 5);
        check("t3_stall_txd", txd_a, 8'h10);
        check("t3_stall_addr", rd_addr_a, 0);
        hold_a = 1'b0;
        wait_idle_a("t3_done");
        build_exp(16'h0002);
        cmp_dump_a("t3");
        check("t3_fc", fc_a, 16'h0003);

        // 4: trigger during SEND is ignored.
        rx_a.delete();
        pulse_trigger_a();
        wait_rx_a(8, "t4_reach8");
        pulse_trigger_a();
        wait_idle_a("t4_done");
        repeat (30) tick();
        check("t4_stay_idle", busy_a, 1'b0);
        build_exp(16'h0003);
        cmp_dump_a("t4");
        check("t4_fc", fc_a, 16'h0004);

        // 5: reset mid-dump.
        rx_a.delete();
        pulse_trigger_a();
        wait_rx_a(10, "t5_reach10");
        reset_a = 1'b1;
        tick();
        check("t5_start",  cap_start_a, 1'b0);
        check("t5_enable", cap_en_a,    1'b0);
        check("t5_addr",   rd_addr_a,   0);
        check("t5_txd",    txd_a,       8'h00);
        check("t5_strobe", strb_a,      1'b0);
        check("t5_busy",   busy_a,      1'b0);
        check("t5_fc",     fc_a,        16'h0000);
        reset_a = 1'b0;
        repeat (20) tick();
        check("t5_quiet", rx_a.size(), 10);
        check("t5_idle", busy_a, 1'b0);

        // 6: auto re-arm with frame counter wrap.
        @(negedge clk);
        reset_b = 1'b0;
        force dut_b.frame_count = 16'hFFFF;
        repeat (2) @(negedge clk);
        release dut_b.frame_count;
        #1;
        wait_rx_b(24, "t6_reach24");
        if (rx_b.size() >= 24) begin
            check("t6_h0", rx_b[0],  8'hA5);
            check("t6_h1", rx_b[1],  8'h5A);
            check("t6_h2", rx_b[2],  8'hFF);
            check("t6_h3", rx_b[3],  8'hFF);
            check("t6_w0", rx_b[4],  8'h10);
            check("t6_w7", rx_b[19], 8'h07);
            check("t6_n0", rx_b[20], 8'hA5);
            check("t6_n1", rx_b[21], 8'h5A);
            check("t6_n2", rx_b[22], 8'h00);
            check("t6_n3", rx_b[23], 8'h00);
        end
        check("t6_fc_wrap", fc_b, 16'h0000);
        check("t6_busy", busy_b, 1'b1);
        check("t6_start", cap_start_b, 1'b0);

        check("no_back_to_back", b2b_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
